// File: rtl/nec_tick_pkg.sv
// Shared types and constants for the NEC tick divider channels.
package nec_tick_pkg;

  typedef enum logic [1:0] {
    TD_IDLE = 2'd0,
    TD_RUN  = 2'd1,
    TD_DONE = 2'd2
  } td_state_e;

  localparam logic TD_PERIODIC = 1'b0;
  localparam logic TD_ONESHOT  = 1'b1;

endpackage

// File: rtl/nec_tick_div_ch.sv
// One divider channel: IDLE/RUN/DONE FSM, tick counter and divisor/mode shadow registers.
// All control inputs and outputs are single-cycle strobes sampled on clk; there is no backpressure.
module nec_tick_div_ch
  import nec_tick_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] div,
  output logic             ch_tick,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  td_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic             mode_q;

  assign state_dbg = state;

  // Priority: rst > stop > start > tick. cnt never passes div_q, so no overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TD_IDLE;
      cnt     <= '0;
      div_q   <= '0;
      mode_q  <= TD_PERIODIC;
      ch_tick <= 1'b0;
      done    <= 1'b0;
    end else begin
      ch_tick <= 1'b0;
      if (stop) begin
        state <= TD_IDLE;
        cnt   <= '0;
        done  <= 1'b0;
      end else if (start) begin
        state  <= TD_RUN;
        cnt    <= '0;
        div_q  <= div;
        mode_q <= mode;
        done   <= 1'b0;
      end else begin
        case (state)
          TD_RUN: begin
            if (tick) begin
              if (cnt == div_q) begin
                cnt     <= '0;
                ch_tick <= 1'b1;
                if (mode_q == TD_ONESHOT) begin
                  state <= TD_DONE;
                  done  <= 1'b1;
                end else begin
                  div_q <= div;
                end
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          TD_IDLE, TD_DONE: ;
          default: begin
            state <= TD_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/nec_tick_div.sv
// Multi-channel tick divider: NCH independent channels sharing one base tick strobe.
module nec_tick_div
  import nec_tick_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NCH-1:0]       ch_start,
  input  logic [NCH-1:0]       ch_stop,
  input  logic [NCH-1:0]       ch_mode,
  input  logic [NCH*CNT_W-1:0] cfg_div,
  output logic [NCH-1:0]       ch_tick,
  output logic [NCH-1:0]       ch_busy,
  output logic [NCH-1:0]       ch_done
);

  logic [1:0] ch_state [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    nec_tick_div_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .start    (ch_start[i]),
      .stop     (ch_stop[i]),
      .mode     (ch_mode[i]),
      .div      (cfg_div[i*CNT_W +: CNT_W]),
      .ch_tick  (ch_tick[i]),
      .done     (ch_done[i]),
      .state_dbg(ch_state[i])
    );

    assign ch_busy[i] = (ch_state[i] == TD_RUN);
  end

endmodule

// File: tb/tb_nec_tick_div.sv
// Bench for nec_tick_div (NCH=2, CNT_W=4): expected ch_tick cycle stamps are queued per channel and matched by a monitor.
module tb_nec_tick_div;

  localparam int NCH   = 2;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic [NCH-1:0]       ch_start = '0;
  logic [NCH-1:0]       ch_stop = '0;
  logic [NCH-1:0]       ch_mode = '0;
  logic [NCH*CNT_W-1:0] cfg_div = '0;
  logic [NCH-1:0]       ch_tick;
  logic [NCH-1:0]       ch_busy;
  logic [NCH-1:0]       ch_done;

  logic [31:0] cyc = '0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int n_checks = 0;
  int n_pass = 0;

  nec_tick_div #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .ch_start(ch_start),
    .ch_stop (ch_stop),
    .ch_mode (ch_mode),
    .cfg_div (cfg_div),
    .ch_tick (ch_tick),
    .ch_busy (ch_busy),
    .ch_done (ch_done)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // scoreboard monitor: a pulse seen at negedge carries the stamp of the edge that produced it
  always @(negedge clk) begin
    logic [31:0] e;
    if (exp_q0.size() > 0 && exp_q0[0] < cyc) begin
      n_checks++;
      $display("FAIL ch0_missed: no pulse at cycle %0d (now %0d)", exp_q0[0], cyc);
      void'(exp_q0.pop_front());
    end
    if (exp_q1.size() > 0 && exp_q1[0] < cyc) begin
      n_checks++;
      $display("FAIL ch1_missed: no pulse at cycle %0d (now %0d)", exp_q1[0], cyc);
      void'(exp_q1.pop_front());
    end
    if (ch_tick[0]) begin
      n_checks++;
      if (exp_q0.size() == 0) $display("FAIL ch0_unexpected: pulse at cycle %0d, none expected", cyc);
      else begin
        e = exp_q0.pop_front();
        if (e !== cyc) $display("FAIL ch0_pulse: got cycle %0d want %0d", cyc, e);
        else n_pass++;
      end
    end
    if (ch_tick[1]) begin
      n_checks++;
      if (exp_q1.size() == 0) $display("FAIL ch1_unexpected: pulse at cycle %0d, none expected", cyc);
      else begin
        e = exp_q1.pop_front();
        if (e !== cyc) $display("FAIL ch1_pulse: got cycle %0d want %0d", cyc, e);
        else n_pass++;
      end
    end
  end

  // driver tasks: inputs change only just after negedge
  task automatic drive(input logic t, input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    tick = t;
    ch_start = st;
    ch_stop = sp;
    @(negedge clk);
    tick = 1'b0;
    ch_start = '0;
    ch_stop = '0;
  endtask

  task automatic setup(input int c, input logic m, input logic [CNT_W-1:0] d);
    cfg_div[c*CNT_W +: CNT_W] = d;
    ch_mode[c] = m;
  endtask

  task automatic drain(input string tag);
    repeat (3) drive(1'b0, '0, '0);
    n_checks++;
    if (exp_q0.size() !== 0) $display("FAIL %s_q0: %0d pulses outstanding, want 0", tag, exp_q0.size());
    else n_pass++;
    n_checks++;
    if (exp_q1.size() !== 0) $display("FAIL %s_q1: %0d pulses outstanding, want 0", tag, exp_q1.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ch_tick !== 2'b00) $display("FAIL reset_tick: got %b want 00", ch_tick); else n_pass++;
    n_checks++;
    if (ch_busy !== 2'b00) $display("FAIL reset_busy: got %b want 00", ch_busy); else n_pass++;
    n_checks++;
    if (ch_done !== 2'b00) $display("FAIL reset_done: got %b want 00", ch_done); else n_pass++;
    rst = 1'b0;
    drive(1'b1, '0, '0);
    drain("reset_idle");
  endtask

  task automatic test_compat();
    setup(0, 1'b0, 4'd7);
    drive(1'b0, 2'b01, '0);
    n_checks++;
    if (ch_busy[0] !== 1'b1) $display("FAIL compat_busy: got %b want 1", ch_busy[0]); else n_pass++;
    for (int k = 1; k <= 64; k++) begin
      if (k % 8 == 0) exp_q0.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
    end
    drive(1'b0, '0, 2'b01);
    drain("compat");
  endtask

  task automatic test_oneshot();
    setup(0, 1'b1, 4'd4);
    drive(1'b0, 2'b01, '0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) exp_q0.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
      if (k == 5) begin
        n_checks++;
        if (ch_done[0] !== 1'b1) $display("FAIL oneshot_done_rise: got %b want 1", ch_done[0]); else n_pass++;
        n_checks++;
        if (ch_busy[0] !== 1'b0) $display("FAIL oneshot_busy_fall: got %b want 0", ch_busy[0]); else n_pass++;
      end
      drive(1'b0, '0, '0);
      drive(1'b0, '0, '0);
    end
    n_checks++;
    if (ch_done[0] !== 1'b1 || ch_busy[0] !== 1'b0)
      $display("FAIL oneshot_hold: done/busy %b/%b want 1/0", ch_done[0], ch_busy[0]);
    else n_pass++;
    drive(1'b0, '0, 2'b01);
    n_checks++;
    if (ch_done[0] !== 1'b0) $display("FAIL oneshot_stop_clear: got %b want 0", ch_done[0]); else n_pass++;
    drain("oneshot");
  endtask

  task automatic test_shadow();
    setup(0, 1'b0, 4'd3);
    drive(1'b0, 2'b01, '0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) setup(0, 1'b0, 4'd1);
      if (k == 4 || k == 6 || k == 8) exp_q0.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
    end
    drive(1'b0, '0, 2'b01);
    drain("shadow");
  endtask

  task automatic test_collisions();
    // start with tick in the same cycle: that tick is not counted
    setup(0, 1'b0, 4'd1);
    drive(1'b1, 2'b01, '0);
    for (int k = 1; k <= 4; k++) begin
      if (k % 2 == 0) exp_q0.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
    end
    drive(1'b0, '0, 2'b01);
    drain("start_tick");
    // stop on the wrap tick
    setup(0, 1'b0, 4'd2);
    drive(1'b0, 2'b01, '0);
    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);
    drive(1'b1, '0, 2'b01);
    n_checks++;
    if (ch_busy[0] !== 1'b0 || ch_done[0] !== 1'b0)
      $display("FAIL stop_wrap_state: busy/done %b/%b want 0/0", ch_busy[0], ch_done[0]);
    else n_pass++;
    repeat (4) drive(1'b1, '0, '0);
    drain("stop_wrap");
    // restart while running with cnt=2
    setup(0, 1'b0, 4'd4);
    drive(1'b0, 2'b01, '0);
    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);
    drive(1'b0, 2'b01, '0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) exp_q0.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
    end
    drive(1'b0, '0, 2'b01);
    drain("restart");
  endtask

  task automatic test_limits();
    setup(1, 1'b0, 4'd0);
    drive(1'b0, 2'b10, '0);
    for (int k = 1; k <= 5; k++) begin
      exp_q1.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
      drive(1'b0, '0, '0);
    end
    drive(1'b0, '0, 2'b10);
    drain("div0");
    setup(0, 1'b0, 4'd15);
    drive(1'b0, 2'b01, '0);
    for (int k = 1; k <= 40; k++) begin
      if (k % 16 == 0) exp_q0.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
    end
    drive(1'b0, '0, 2'b01);
    drain("div_max");
  endtask

  task automatic test_two_channels();
    setup(0, 1'b0, 4'd2);
    setup(1, 1'b1, 4'd5);
    drive(1'b0, 2'b11, '0);
    for (int k = 1; k <= 20; k++) begin
      if (k % 3 == 0) exp_q0.push_back(cyc + 32'd1);
      if (k == 6) exp_q1.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
    end
    n_checks++;
    if (ch_done !== 2'b10) $display("FAIL two_ch_done: got %b want 10", ch_done); else n_pass++;
    n_checks++;
    if (ch_busy !== 2'b01) $display("FAIL two_ch_busy: got %b want 01", ch_busy); else n_pass++;
    drive(1'b0, '0, 2'b11);
    drain("two_ch");
  endtask

  task automatic test_reset_mid();
    setup(0, 1'b0, 4'd7);
    setup(1, 1'b1, 4'd1);
    drive(1'b0, 2'b11, '0);
    repeat (2) drive(1'b1, '0, '0);
    exp_q1.push_back(cyc);
    repeat (3) drive(1'b1, '0, '0);
    n_checks++;
    if (ch_done[1] !== 1'b1) $display("FAIL mid_pre_done: got %b want 1", ch_done[1]); else n_pass++;
    rst = 1'b1;
    drive(1'b1, '0, '0);
    n_checks++;
    if (ch_tick !== 2'b00 || ch_busy !== 2'b00 || ch_done !== 2'b00)
      $display("FAIL mid_reset_outs: tick/busy/done %b/%b/%b want 00/00/00", ch_tick, ch_busy, ch_done);
    else n_pass++;
    rst = 1'b0;
    repeat (10) drive(1'b1, '0, '0);
    n_checks++;
    if (ch_busy !== 2'b00) $display("FAIL mid_idle_busy: got %b want 00", ch_busy); else n_pass++;
    drive(1'b0, 2'b01, '0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) exp_q0.push_back(cyc + 32'd1);
      drive(1'b1, '0, '0);
    end
    drive(1'b0, '0, 2'b01);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_compat();
    test_oneshot();
    test_shadow();
    test_collisions();
    test_limits();
    test_two_channels();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
